// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and state encoding for the SHA-256 message padder
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int NUM_WORDS = BLOCK_W / WORD_W;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Index of the last padding word before the two length words.
    localparam logic [3:0] LAST_PAD_IDX = 4'd13;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD  = 3'd2,
        LEN  = 3'd3,
        EMIT = 3'd4
    } pad_state_e;

endpackage

// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - word input stream and block output bundle of the SHA-256 padder
// Purpose: groups the message-word handshake (s_*) and the padded-block
//          handshake (block*) into one bundle.
// Modports:
//   master - message source / block consumer (drives s_valid, s_data, s_bytes,
//            s_last, block_ready)
//   slave  - the padder (drives s_ready, block, block_valid, block_first,
//            block_last)
interface sha256_padder_if;
    import sha256_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [WORD_W-1:0]  s_data;
    logic [2:0]         s_bytes;
    logic               s_last;
    logic [BLOCK_W-1:0] block;
    logic               block_valid;
    logic               block_ready;
    logic               block_first;
    logic               block_last;

    modport master (
        output s_valid, s_data, s_bytes, s_last, block_ready,
        input  s_ready, block, block_valid, block_first, block_last
    );

    modport slave (
        input  s_valid, s_data, s_bytes, s_last, block_ready,
        output s_ready, block, block_valid, block_first, block_last
    );

endinterface

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - masks a final partial word and inserts the 0x80 pad byte
// Purpose: for a last word with fewer than four valid bytes, keeps bytes
//          0..n-1, puts 0x80 in byte n and zeroes the rest; any other word
//          passes through unchanged.
// Ports:
//   data_i  - message word, first byte in [31:24]
//   bytes_i - valid byte count (0..4)
//   last_i  - word is the final word of the message
//   word_o  - word to store in the block buffer
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [2:0]        bytes_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] word_o
);

    always_comb begin
        word_o = data_i;
        if (last_i && (bytes_i < 3'd4)) begin
            for (int b = 0; b < 4; b++) begin
                if (b == int'(bytes_i)) begin
                    word_o[WORD_W-1-8*b -: 8] = PAD_BYTE;
                end else if (b > int'(bytes_i)) begin
                    word_o[WORD_W-1-8*b -: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - assembles message words into padded 512-bit SHA-256 blocks
// Purpose: buffers 16 message words per block, appends the 0x80 marker, zero
//          fill and the 64-bit big-endian bit length, spilling into a second
//          block when the marker leaves no room for the length.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-high reset, discards any partial message
//   bus   - slave side of sha256_padder_if (word input, block output)
// Parameters:
//   LEN_W - width of the bit-length counter (2..64), upper length bits zero
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
)
(
    input  logic            clk,
    input  logic            reset,
    sha256_padder_if.slave  bus
);

    pad_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WORD_W-1:0] buf_q [NUM_WORDS];
    logic              first_q, first_d;
    logic              last_q, last_d;
    // Final word has been accepted; remaining blocks come from PAD, not FILL.
    logic              done_q, done_d;
    // A full final word was taken; the next PAD write is the 0x80 word.
    logic              pad80_q, pad80_d;
    // Marker lands at index 14/15, so the length must go in a second block.
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              full_word;
    logic [2:0]        bytes_eff;
    logic [WORD_W-1:0] in_word;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              len_wr;
    logic [63:0]       len64;

    assign bus.s_ready     = (state_q == IDLE) || (state_q == FILL);
    assign bus.block_valid = (state_q == EMIT);
    assign bus.block_first = (state_q == EMIT) && first_q;
    assign bus.block_last  = (state_q == EMIT) && last_q;

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_block
        assign bus.block[BLOCK_W-1-WORD_W*gi -: WORD_W] = buf_q[gi];
    end

    assign accept    = bus.s_valid && bus.s_ready;
    // Byte count only matters on the last word; out-of-range counts act as 4.
    assign bytes_eff = (bus.s_last && (bus.s_bytes < 3'd4)) ? bus.s_bytes : 3'd4;
    assign full_word = (bytes_eff == 3'd4);
    assign len64     = 64'(len_q);

    sha256_pad_word u_pad_word (
        .data_i  (bus.s_data),
        .bytes_i (bus.s_bytes),
        .last_i  (bus.s_last),
        .word_o  (in_word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        first_d = first_q;
        last_d  = last_q;
        done_d  = done_q;
        pad80_d = pad80_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_data = in_word;
        len_wr  = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 4'd1;
                    len_d = len_q + LEN_W'({bytes_eff, 3'b000});
                    if (state_q == IDLE) begin
                        first_d = 1'b1;
                    end
                    if (bus.s_last) begin
                        done_d  = 1'b1;
                        pad80_d = full_word;
                        ovf_d   = full_word ? (idx_q >= 4'd13) : (idx_q >= 4'd14);
                        if (idx_q == 4'd15) begin
                            state_d = EMIT;
                            last_d  = 1'b0;
                        end else if (!full_word && (idx_q == LAST_PAD_IDX)) begin
                            state_d = LEN;
                        end else begin
                            state_d = PAD;
                        end
                    end else if (idx_q == 4'd15) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            PAD: begin
                wr_en   = 1'b1;
                wr_data = pad80_q ? {PAD_BYTE, 24'h000000} : '0;
                pad80_d = 1'b0;
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = EMIT;
                    last_d  = 1'b0;
                end else if ((idx_q == LAST_PAD_IDX) && !ovf_q) begin
                    state_d = LEN;
                end
            end

            LEN: begin
                len_wr  = 1'b1;
                idx_d   = 4'd0;
                last_d  = 1'b1;
                state_d = EMIT;
            end

            EMIT: begin
                if (bus.block_ready) begin
                    first_d = 1'b0;
                    ovf_d   = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        len_d   = '0;
                        done_d  = 1'b0;
                        last_d  = 1'b0;
                    end else if (done_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            len_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            pad80_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
            pad80_q <= pad80_d;
            ovf_q   <= ovf_d;
            if (wr_en) begin
                buf_q[idx_q] <= wr_data;
            end
            if (len_wr) begin
                buf_q[14] <= len64[63:32];
                buf_q[15] <= len64[31:0];
            end
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - self-checking bench for sha256_padder
module tb_sha256_padder;
    import sha256_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    byte unsigned       msg[$];
    logic [BLOCK_W-1:0] exp_blk[$];

    sha256_padder_if bus();

    sha256_padder #(.LEN_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Textbook SHA-256 padding on a byte list, then cut into 64-byte blocks.
    task automatic model();
        byte unsigned       p[$];
        logic [63:0]        bits;
        logic [BLOCK_W-1:0] blk;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_blk.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[BLOCK_W-1-8*j -: 8] = p[64*b+j];
            exp_blk.push_back(blk);
        end
    endtask

    // Present word wi of msg; bytes past the valid count are random junk.
    task automatic drive_word(input int wi, input int n, input int nw);
        logic [31:0] w;
        int          nb;
        nb = (wi == nw - 1) ? n - 4*wi : 4;
        w  = $urandom;
        for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg[4*wi+j];
        bus.s_data  = w;
        bus.s_bytes = 3'(nb);
        bus.s_last  = (wi == nw - 1);
    endtask

    task automatic run_msg(input int gap_pct, input int bp_pct);
        int n, nw, wi, bi, cyc;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        model();
        wi = 0; bi = 0; cyc = 0;
        @(negedge clk);
        while ((wi < nw || bi < exp_blk.size()) && cyc < 4000) begin
            if (wi < nw) begin
                drive_word(wi, n, nw);
                bus.s_valid = ($urandom_range(0, 99) >= gap_pct);
            end else begin
                bus.s_valid = 1'b0;
            end
            bus.block_ready = ($urandom_range(0, 99) >= bp_pct);
            #1;
            if (bus.s_valid && bus.s_ready) wi++;
            if (bus.block_valid) begin
                chk("emit_s_ready", 512'(bus.s_ready), 512'(0));
                if (bus.block_ready) begin
                    if (bi < exp_blk.size()) begin
                        chk($sformatf("len%0d_blk%0d", n, bi), bus.block, exp_blk[bi]);
                        chk($sformatf("len%0d_first%0d", n, bi), 512'(bus.block_first), 512'(bi == 0));
                        chk($sformatf("len%0d_last%0d", n, bi), 512'(bus.block_last), 512'(bi == exp_blk.size() - 1));
                    end
                    bi++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid     = 1'b0;
        bus.block_ready = 1'b0;
        chk($sformatf("len%0d_timeout", n), 512'(cyc >= 4000), 512'(0));
        #1;
        chk($sformatf("len%0d_idle_valid", n), 512'(bus.block_valid), 512'(0));
        chk($sformatf("len%0d_idle_ready", n), 512'(bus.s_ready), 512'(1));
    endtask

    initial begin
        logic [BLOCK_W-1:0] snap;
        int                 lat;
        int                 lens[10];

        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_bytes     = 3'd0;
        bus.s_last      = 1'b0;
        bus.block_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 512'(bus.block_valid), 512'(0));
        chk("rst_first", 512'(bus.block_first), 512'(0));
        chk("rst_last", 512'(bus.block_last), 512'(0));
        chk("rst_block", bus.block, 512'(0));
        reset = 1'b0;
        #1;
        chk("rst_s_ready", 512'(bus.s_ready), 512'(1));

        // "abc" with latency measured from the accepting edge
        msg = {8'h61, 8'h62, 8'h63};
        @(negedge clk);
        drive_word(0, 3, 1);
        bus.s_valid     = 1'b1;
        bus.block_ready = 1'b1;
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        lat = 0;
        while (!bus.block_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        chk("abc_latency", 512'(lat), 512'(14));
        chk("abc_block", bus.block, {32'h61626380, 448'h0, 32'h00000018});
        chk("abc_first", 512'(bus.block_first), 512'(1));
        chk("abc_last", 512'(bus.block_last), 512'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("abc_done_valid", 512'(bus.block_valid), 512'(0));
        chk("abc_done_ready", 512'(bus.s_ready), 512'(1));

        // Backpressure in EMIT with a word offered that must be ignored
        @(negedge clk);
        drive_word(0, 3, 1);
        bus.s_valid     = 1'b1;
        bus.block_ready = 1'b0;
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        lat = 0;
        while (!bus.block_valid && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("bp_reach_emit", 512'(bus.block_valid), 512'(1));
        snap = bus.block;
        chk("bp_block", snap, {32'h61626380, 448'h0, 32'h00000018});
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEADBEEF;
        bus.s_bytes = 3'd4;
        bus.s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold_block%0d", c), bus.block, snap);
            chk($sformatf("bp_hold_valid%0d", c), 512'(bus.block_valid), 512'(1));
            chk($sformatf("bp_hold_flags%0d", c), 512'({bus.block_first, bus.block_last}), 512'(3));
            chk($sformatf("bp_hold_s_ready%0d", c), 512'(bus.s_ready), 512'(0));
        end
        bus.s_valid     = 1'b0;
        bus.block_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.block_ready = 1'b0;
        #1;
        chk("bp_release_valid", 512'(bus.block_valid), 512'(0));
        chk("bp_release_ready", 512'(bus.s_ready), 512'(1));
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(0, 0);

        // Reset pulse while the first message is padding
        make_msg(10);
        bus.block_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_word(i, 10, 3);
            bus.s_valid = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pad_s_ready", 512'(bus.s_ready), 512'(0));
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", 512'(bus.block_valid), 512'(0));
        chk("midrst_block", bus.block, 512'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_s_ready", 512'(bus.s_ready), 512'(1));
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(0, 0);

        // Boundary lengths: empty, marker at word 13/14/15, full blocks
        lens = '{0, 55, 56, 57, 60, 63, 64, 65, 119, 128};
        foreach (lens[i]) begin
            make_msg(lens[i]);
            run_msg(20, 20);
        end

        // Random lengths with random gaps and backpressure
        for (int r = 0; r < 8; r++) begin
            make_msg(int'($urandom_range(0, 140)));
            run_msg(30, 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 Parameter: LEN_W, 64, width of the message bit-length counter (2..64); length field bits above LEN_W are zero.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_valid  input  1  input word valid.
REQ-005 s_ready  output  1  padder accepts a word on the edge where s_valid && s_ready.
REQ-006 s_data  input  32  message word, big-endian; first byte in [31:24].
REQ-007 s_bytes  input  3  valid bytes in word (0..4), left-aligned; honoured only with s_last, otherwise treated as 4.
REQ-008 s_last  input  1  word is the final word of the message.
REQ-009 block  output  512  padded block; word 0 in [511:480].
REQ-010 block_valid  output  1  block holds a complete 512-bit block.
REQ-011 block_ready  input  1  downstream consumes block on edge where block_valid && block_ready.
REQ-012 block_first  output  1  first block of message (downstream issues init), else next.
REQ-013 block_last  output  1  final block of message (contains length).

Function
REQ-014 The FSM SHALL have states IDLE, FILL, PAD, LEN, EMIT; s_ready = 1 only in IDLE and FILL.
REQ-015 An accepted word SHALL be stored at buffer index idx (0..15), idx increments, and the length counter increments by 8*bytes, wrapping modulo 2^LEN_W.
REQ-016 Acceptance moves IDLE to FILL; block_first SHALL be 1 for the first emitted block after leaving IDLE, 0 thereafter.
REQ-017 Non-last word landing at idx 15 SHALL move FSM to EMIT with block_last = 0; after the handshake FSM returns to FILL with idx = 0.
REQ-018 Last word with s_bytes = n < 4: bytes 0..n-1 kept, byte n = 0x80, remaining bytes zero; s_data bytes beyond n ignored.
REQ-019 Last word with s_bytes = 4: stored unchanged; word 0x80000000 written at next index in the first PAD cycle.
REQ-020 PAD SHALL write one word per cycle (0x80 word per REQ-019, else zero) until index 13 is written, then go to LEN.
REQ-021 LEN SHALL write the 64-bit length into words 14 (high) and 15 (low) in one cycle, then go to EMIT with block_last = 1.
REQ-022 Overflow: if the 0x80 byte lands at index 14 or 15, PAD SHALL zero-fill to index 15, emit with block_last = 0, then build a second block of zeros at indices 0..13 plus the length.
REQ-023 Latency: for a last word at index k <= 13 with s_bytes < 4, block_valid SHALL rise 14-k clock edges after the accepting edge.
REQ-024 In EMIT, block and block_* SHALL hold stable while block_ready = 0; s_ready = 0.
REQ-025 After the block_last handshake, FSM SHALL return to IDLE and clear idx, length counter and block_first tracking.
REQ-026 block_ready asserted outside EMIT SHALL have no effect; s_valid outside IDLE/FILL SHALL not be accepted.

Reset
REQ-027 While reset: state IDLE, idx 0, length 0, buffer all zero, block_valid 0, block_first 0, block_last 0, block 0; s_ready = 1 after release.
REQ-028 Reset asserted mid-message (any state) SHALL discard the partial message; no block emitted for it.

Structure
REQ-029 Shared package sha256_pkg SHALL hold WORD_W = 32, BLOCK_W = 512, PAD_BYTE = 8'h80, and the padder state encoding.
REQ-030 Sub-module sha256_pad_word (combinational byte mask + 0x80 insertion from s_data, s_bytes) is natural; rest is one module.

Verification
REQ-031 "abc": s_data 0x61626300, s_bytes 3, s_last -> one block: word0 0x61626380, words1-14 0, word15 0x00000018, first = last = 1, 14 edges after accept.
REQ-032 Empty message: s_bytes 0, s_last -> word0 0x80000000, all else 0, word15 0x00000000, first = last = 1.
REQ-033 56-byte message (14 full words, last s_bytes 4) -> block A: word14 0x80000000, word15 0, first 1, last 0; block B: all zero, word15 0x000001C0, first 0, last 1.
REQ-034 64-byte message -> block A data only, first 1, last 0; block B word0 0x80000000, word15 0x00000200, last 1.
REQ-035 Backpressure: block_ready held 0 for 5 cycles in EMIT -> block, block_valid, first, last stable; s_ready 0; single handshake on release.
REQ-036 Reset pulse during PAD of one message, then "abc" -> no block for first message; "abc" block exactly as REQ-031.
